// File: rtl/output_layer_mac.sv
// Output dense layer: buffers N_IN activations, then serially computes N_OUT
// saturated Q8.8 logits against an external synchronous weight ROM.
module output_layer_mac #(
   parameter int N_IN  = 32,
   parameter int N_OUT = 10,
   parameter int AW    = 9,
   parameter int FRAC  = 7
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [15:0]   act_in,
   input  logic          act_valid,
   output logic          act_ready,
   output logic [AW-1:0] w_addr,
   output logic          w_rd_en,
   input  logic [7:0]    w_data,
   output logic [3:0]    b_addr,
   input  logic [15:0]   b_data,
   output logic [15:0]   out_data,
   output logic          out_valid,
   output logic          out_start,
   output logic          busy,
   output logic          done,
   output logic          dbg_state_o
);

   localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int CW = $clog2(N_IN + 2);

   typedef enum logic [0:0] {
      S_LOAD    = 1'b0,
      S_COMPUTE = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [IW-1:0]        in_cnt_q, in_cnt_d;
   logic [CW-1:0]        cyc_q, cyc_d;
   logic [3:0]           j_q, j_d;
   logic signed [31:0]   acc_q, acc_d;
   logic                 done_q, done_d;
   logic signed [15:0]   buf_q [N_IN];

   logic [IW-1:0]        rd_idx;
   logic signed [23:0]   prod;
   logic signed [31:0]   acc_sh;
   logic signed [32:0]   sum;
   logic [15:0]          sat;
   logic                 accum_en;
   logic                 final_en;

   // Weight for activation i arrives one cycle after its address, so slot cycle c consumes buffer[c-1].
   assign rd_idx   = IW'(cyc_q - CW'(1));
   assign prod     = 24'(buf_q[rd_idx]) * 24'($signed(w_data));
   assign accum_en = (state_q == S_COMPUTE) && (cyc_q != '0) && (cyc_q <= CW'(N_IN));
   assign final_en = (state_q == S_COMPUTE) && (cyc_q == CW'(N_IN + 1));

   assign acc_sh = acc_q >>> FRAC;
   assign sum    = 33'(acc_sh) + 33'($signed(b_data));

   always_comb begin
      sat = sum[15:0];
      if (sum > 33'sd32767) begin
         sat = 16'h7FFF;
      end else if (sum < -33'sd32768) begin
         sat = 16'h8000;
      end
   end

   always_comb begin
      state_d  = state_q;
      in_cnt_d = in_cnt_q;
      cyc_d    = cyc_q;
      j_d      = j_q;
      acc_d    = acc_q;
      done_d   = 1'b0;
      case (state_q)
         S_LOAD: begin
            if (act_valid) begin
               if (in_cnt_q == IW'(N_IN - 1)) begin
                  in_cnt_d = '0;
                  cyc_d    = '0;
                  j_d      = '0;
                  acc_d    = '0;
                  state_d  = S_COMPUTE;
               end else begin
                  in_cnt_d = in_cnt_q + IW'(1);
               end
            end
         end
         S_COMPUTE: begin
            if (accum_en) begin
               acc_d = acc_q + 32'(prod);
            end
            if (final_en) begin
               acc_d = '0;
               cyc_d = '0;
               if (j_q == 4'(N_OUT - 1)) begin
                  j_d     = '0;
                  done_d  = 1'b1;
                  state_d = S_LOAD;
               end else begin
                  j_d = j_q + 4'd1;
               end
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_LOAD;
         in_cnt_q <= '0;
         cyc_q    <= '0;
         j_q      <= '0;
         acc_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         in_cnt_q <= in_cnt_d;
         cyc_q    <= cyc_d;
         j_q      <= j_d;
         acc_q    <= acc_d;
         done_q   <= done_d;
      end
   end

   // Activation buffer holds data only; it needs no reset.
   always_ff @(posedge clk) begin
      if (state_q == S_LOAD && act_valid) begin
         buf_q[in_cnt_q] <= act_in;
      end
   end

   assign act_ready   = (state_q == S_LOAD);
   assign busy        = (state_q == S_COMPUTE);
   assign out_start   = (state_q == S_COMPUTE);
   assign w_rd_en     = (state_q == S_COMPUTE) && (cyc_q < CW'(N_IN));
   assign w_addr      = AW'(j_q) * AW'(N_IN) + AW'(cyc_q);
   assign b_addr      = j_q;
   assign out_valid   = final_en;
   assign out_data    = final_en ? sat : 16'h0000;
   assign done        = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_output_layer_mac.sv
// Directed bench for output_layer_mac: weight ROM and bias table models,
// hand-computed logit expectations checked by immediate assertions.
module tb_output_layer_mac;

   localparam int N_IN  = 32;
   localparam int N_OUT = 10;
   localparam int AW    = 9;
   localparam int FRAC  = 7;
   localparam int SLOT  = N_IN + 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [15:0]   act_in;
   logic          act_valid;
   logic          act_ready;
   logic [AW-1:0] w_addr;
   logic          w_rd_en;
   logic [7:0]    w_data;
   logic [3:0]    b_addr;
   logic [15:0]   b_data;
   logic [15:0]   out_data;
   logic          out_valid;
   logic          out_start;
   logic          busy;
   logic          done;
   logic          dbg_state;

   logic [7:0]    rom [1 << AW];
   logic [15:0]   bias_mem [16];
   logic [15:0]   act_vec [N_IN];
   logic [15:0]   obs_log [N_OUT];
   logic [15:0]   exp_q [$];
   int            checks = 0;
   int            errors = 0;

   output_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW), .FRAC(FRAC)) dut (
      .clk(clk), .reset_n(reset_n), .act_in(act_in), .act_valid(act_valid),
      .act_ready(act_ready), .w_addr(w_addr), .w_rd_en(w_rd_en), .w_data(w_data),
      .b_addr(b_addr), .b_data(b_data), .out_data(out_data), .out_valid(out_valid),
      .out_start(out_start), .busy(busy), .done(done), .dbg_state_o(dbg_state)
   );

   // clock / memories
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (w_rd_en) w_data <= rom[w_addr];
   end

   assign b_data = bias_mem[b_addr];

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // driver / checker tasks
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_weights(input logic [7:0] w);
      for (int i = 0; i < (1 << AW); i++) rom[i] = w;
   endtask

   task automatic fill_bias(input logic [15:0] step);
      for (int j = 0; j < 16; j++) bias_mem[j] = 16'(j) * step;
   endtask

   task automatic fill_acts(input logic [15:0] v);
      for (int i = 0; i < N_IN; i++) act_vec[i] = v;
   endtask

   task automatic push_ramp(input logic [15:0] base, input logic [15:0] step);
      for (int j = 0; j < N_OUT; j++) exp_q.push_back(base + 16'(j) * step);
   endtask

   task automatic load_acts(input bit gaps, input bit hold);
      for (int i = 0; i < N_IN; i++) begin
         if (gaps && (i % 3 == 1)) begin
            act_valid = 1'b0;
            act_in    = 16'hDEAD;
            @(negedge clk);
         end
         check("load_ready", {31'b0, act_ready}, 1);
         act_valid = 1'b1;
         act_in    = act_vec[i];
         @(negedge clk);
      end
      act_valid = hold;
      act_in    = 16'h5A5A;
   endtask

   task automatic run_burst();
      int k;
      int seen;
      int slot;
      int c;
      bit fin;
      k = 0;
      seen = 0;
      fin = 1'b0;
      while (!fin && k <= SLOT * N_OUT + 4) begin
         if (done) begin
            check("done_k", 32'(k), 32'(SLOT * N_OUT));
            check("done_ready", {31'b0, act_ready}, 1);
            check("done_busy", {31'b0, busy}, 0);
            check("done_start", {31'b0, out_start}, 0);
            fin = 1'b1;
         end else begin
            slot = k / SLOT;
            c    = k % SLOT;
            check("busy", {31'b0, busy}, 1);
            check("out_start", {31'b0, out_start}, 1);
            check("ready_compute", {31'b0, act_ready}, 0);
            check("b_addr", {28'b0, b_addr}, 32'(slot));
            check("w_rd_en", {31'b0, w_rd_en}, (c < N_IN) ? 32'd1 : 32'd0);
            if (c < N_IN) check("w_addr", {23'b0, w_addr}, 32'(slot * N_IN + c));
            check("out_valid", {31'b0, out_valid}, (c == N_IN + 1) ? 32'd1 : 32'd0);
            if (out_valid && exp_q.size() != 0) begin
               check("logit", {16'b0, out_data}, {16'b0, exp_q.pop_front()});
               if (seen < N_OUT) obs_log[seen] = out_data;
               seen++;
            end
            @(negedge clk);
            k++;
         end
      end
      check("burst_done", {31'b0, fin}, 1);
      check("burst_count", 32'(seen), 32'(N_OUT));
      check("exp_left", 32'(exp_q.size()), 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ready"}, {31'b0, act_ready}, 1);
      check({tag, "_rd_en"}, {31'b0, w_rd_en}, 0);
      check({tag, "_w_addr"}, {23'b0, w_addr}, 0);
      check({tag, "_b_addr"}, {28'b0, b_addr}, 0);
      check({tag, "_data"}, {16'b0, out_data}, 0);
      check({tag, "_valid"}, {31'b0, out_valid}, 0);
      check({tag, "_start"}, {31'b0, out_start}, 0);
      check({tag, "_busy"}, {31'b0, busy}, 0);
      check({tag, "_done"}, {31'b0, done}, 0);
   endtask

   // directed sequence
   initial begin
      int best;
      reset_n   = 1'b0;
      act_valid = 1'b0;
      act_in    = 16'h0000;
      fill_weights(8'h00);
      fill_bias(16'h0000);
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // uniform 1.0 x 0.5 with bias ramp -> 16.0 + j
      fill_weights(8'h40);
      fill_bias(16'h0100);
      fill_acts(16'h0100);
      push_ramp(16'h1000, 16'h0100);
      load_acts(1'b0, 1'b0);
      run_burst();
      @(negedge clk);
      check("done_pulse", {31'b0, done}, 0);

      // only neuron 7 has nonzero weights -> unique maximum
      fill_weights(8'h00);
      for (int i = 0; i < N_IN; i++) rom[7 * N_IN + i] = 8'h7F;
      fill_bias(16'h0000);
      for (int j = 0; j < N_OUT; j++) exp_q.push_back((j == 7) ? 16'h1FC0 : 16'h0000);
      load_acts(1'b0, 1'b0);
      run_burst();
      best = 0;
      for (int j = 1; j < N_OUT; j++)
         if ($signed(obs_log[j]) > $signed(obs_log[best])) best = j;
      check("argmax", 32'(best), 7);
      @(negedge clk);

      // positive and negative saturation
      fill_weights(8'h7F);
      for (int j = 0; j < 16; j++) bias_mem[j] = 16'h7FFF;
      fill_acts(16'h7FFF);
      push_ramp(16'h7FFF, 16'h0000);
      load_acts(1'b0, 1'b0);
      run_burst();
      @(negedge clk);
      fill_weights(8'h80);
      push_ramp(16'h8000, 16'h0000);
      load_acts(1'b0, 1'b0);
      run_burst();
      @(negedge clk);

      // arithmetic shift of a small negative sum: -32 >>> 7 = -1
      fill_weights(8'h01);
      fill_bias(16'h0100);
      fill_acts(16'hFFFF);
      push_ramp(16'hFFFF, 16'h0100);
      load_acts(1'b0, 1'b0);
      run_burst();
      @(negedge clk);

      // gapped load, act_valid held high through compute
      fill_weights(8'h40);
      fill_acts(16'h0100);
      push_ramp(16'h1000, 16'h0100);
      load_acts(1'b1, 1'b1);
      run_burst();
      act_valid = 1'b0;
      @(negedge clk);

      // reset mid-slot of neuron 4, then a fresh burst
      push_ramp(16'h1000, 16'h0100);
      load_acts(1'b0, 1'b0);
      repeat (4 * SLOT + 15) @(negedge clk);
      check("pre_reset_b_addr", {28'b0, b_addr}, 4);
      check("pre_reset_busy", {31'b0, busy}, 1);
      reset_n = 1'b0;
      #1;
      check_idle_outputs("abort");
      exp_q.delete();
      repeat (3) begin
         @(negedge clk);
         check("abort_hold_valid", {31'b0, out_valid}, 0);
      end
      reset_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         check("post_abort_valid", {31'b0, out_valid}, 0);
         check("post_abort_busy", {31'b0, busy}, 0);
      end
      push_ramp(16'h1000, 16'h0100);
      load_acts(1'b0, 1'b0);
      run_burst();
      @(negedge clk);

      // back-to-back: second load starts in the done cycle
      push_ramp(16'h1000, 16'h0100);
      load_acts(1'b0, 1'b0);
      run_burst();
      fill_acts(16'hFF00);
      push_ramp(16'hF000, 16'h0100);
      load_acts(1'b0, 1'b0);
      run_burst();
      @(negedge clk);
      check("final_state", {31'b0, dbg_state}, 0);

      // report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
